// File: rtl/branch_judge_bht.sv
// Branch resolution stage with registered result and a 2-bit saturating-counter BHT.
// Optional BRANCH_STATS_EN adds branch/mispredict event counters.
module branch_judge_bht #(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             lookup_taken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [2:0]       b_ctrl,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [PC_W-1:0]  out_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  // Handshake: a transfer happens on any edge where valid && ready are both high.
  // in_ready = !out_valid || out_ready, so the single output register can be refilled
  // in the same cycle it drains; flush overrides both the drain update and a refill.
  logic             accept;
  logic             out_fire;
  logic             update_en;
  logic             cmp_taken;
  logic             rs_neg;
  logic             rs_zero;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       next_ctr;
  logic [1:0]       bht [BHT_DEPTH];
  logic             unused_lookup_bits;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign update_en = out_fire && !flush;

  assign lookup_idx   = lookup_pc[IDX_W+1:2];
  assign update_idx   = out_pc[IDX_W+1:2];
  assign lookup_taken = bht[lookup_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[1:0], lookup_pc[PC_W-1:IDX_W+2]};

  // Signed zero/negative tests need only the sign bit and a zero detect.
  assign rs_neg  = rs_val[WIDTH-1];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    cmp_taken = 1'b0;
    case (b_ctrl)
      3'b000:  cmp_taken = 1'b0;
      3'b001:  cmp_taken = (rs_val == rt_val);
      3'b010:  cmp_taken = (rs_val != rt_val);
      3'b011:  cmp_taken = rs_neg || rs_zero;
      3'b100:  cmp_taken = !rs_neg && !rs_zero;
      3'b101:  cmp_taken = rs_neg;
      3'b110:  cmp_taken = !rs_neg;
      default: cmp_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_pc         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_taken      <= cmp_taken;
      out_mispredict <= (cmp_taken != pred_taken);
      out_pc         <= in_pc;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign cur_ctr = bht[update_idx];

  always_comb begin
    next_ctr = cur_ctr;
    if (out_taken) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'd1;
    end
  end

  // Lookup reads the array directly, so a same-cycle update is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (update_en) begin
      bht[update_idx] <= next_ctr;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (update_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (out_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_judge_bht.sv
// Self-checking bench for branch_judge_bht: randomized and directed scenarios
// checked against a counter-array reference model.
module tb_branch_judge_bht;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [2:0]  b_ctrl;
  logic        pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_mispredict;
  logic [31:0] out_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int model_ctr[DEPTH];

  branch_judge_bht #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .rs_val(rs_val),
    .rt_val(rt_val), .b_ctrl(b_ctrl), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_pc(out_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit ref_taken(logic [2:0] c, logic [31:0] rs, logic [31:0] rt);
    int srs;
    srs = rs;
    case (c)
      3'd0: return 1'b0;
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return srs <= 0;
      3'd4: return srs > 0;
      3'd5: return srs < 0;
      3'd6: return srs >= 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_update(logic [31:0] pc, bit taken);
    int i;
    i = idx_of(pc);
    if (taken) model_ctr[i] = (model_ctr[i] >= 3) ? 3 : model_ctr[i] + 1;
    else       model_ctr[i] = (model_ctr[i] <= 0) ? 0 : model_ctr[i] - 1;
  endfunction

  function automatic bit model_pred(logic [31:0] pc);
    return model_ctr[idx_of(pc)] >= 2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_ctr[i] = 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    b_ctrl = 3'd0; rs_val = '0; rt_val = '0; pred_taken = 1'b0; in_pc = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    lookup_pc = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One request with out_ready high: accept edge, then drain edge.
  task automatic send(input logic [31:0] pc, input logic [2:0] c, input logic [31:0] rs,
                      input logic [31:0] rt, input logic pred,
                      output logic ov, output logic ot, output logic om, output logic [31:0] opc);
    in_pc = pc; b_ctrl = c; rs_val = rs; rt_val = rt; pred_taken = pred;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    tick();
    ov = out_valid; ot = out_taken; om = out_mispredict; opc = out_pc;
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_taken !== 1'b0 || out_mispredict !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_flags: got taken=%b mis=%b expected 0/0", out_taken, out_mispredict);
    end
    tests_run++;
    if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      lookup_pc = 32'h3000 + 32'(4 * i);
      #1;
      tests_run++;
      if (lookup_taken !== model_pred(lookup_pc)) begin
        tests_failed++; $display("FAIL reset_lookup pc=%h: got %b expected %b", lookup_pc, lookup_taken, model_pred(lookup_pc));
      end
    end
  endtask

  task automatic test_first_branch();
    logic ov, ot, om;
    logic [31:0] opc;
    bit et;
    send(32'h3004, 3'b001, 32'd5, 32'd5, 1'b0, ov, ot, om, opc);
    et = ref_taken(3'b001, 32'd5, 32'd5);
    tests_run++;
    if (ov !== 1'b1 || ot !== et || om !== (et != 1'b0) || opc !== 32'h3004) begin
      tests_failed++;
      $display("FAIL first_beq: got v=%b t=%b m=%b pc=%h expected v=1 t=%b m=%b pc=3004", ov, ot, om, opc, et, et != 1'b0);
    end
    model_update(32'h3004, et);
    lookup_pc = 32'h3004;
    #1;
    tests_run++;
    if (lookup_taken !== model_pred(32'h3004)) begin
      tests_failed++; $display("FAIL first_lookup: got %b expected %b", lookup_taken, model_pred(32'h3004));
    end
  endtask

  task automatic test_compare_modes();
    logic ov, ot, om;
    logic [31:0] opc, pc, rs, rt;
    logic [2:0] c;
    logic pred;
    bit et;
    logic [2:0]  dir_c[3]  = '{3'b011, 3'b100, 3'b110};
    logic [31:0] dir_rs[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    for (int k = 0; k < 43; k++) begin
      if (k < 3) begin
        c = dir_c[k]; rs = dir_rs[k]; rt = 32'h0; pred = 1'b0;
        pc = 32'h3018;
      end else begin
        c = 3'($urandom_range(0, 7));
        rs = rand_operand();
        rt = ($urandom_range(0, 1) == 1) ? rs : rand_operand();
        pred = 1'($urandom_range(0, 1));
        pc = 32'h3000 + 32'(4 * $urandom_range(0, DEPTH - 1));
      end
      send(pc, c, rs, rt, pred, ov, ot, om, opc);
      et = ref_taken(c, rs, rt);
      tests_run++;
      if (ov !== 1'b1 || ot !== et || om !== (et != pred) || opc !== pc) begin
        tests_failed++;
        $display("FAIL compare ctrl=%0d rs=%h rt=%h: got v=%b t=%b m=%b pc=%h expected v=1 t=%b m=%b pc=%h",
                 c, rs, rt, ov, ot, om, opc, et, et != pred, pc);
      end
      model_update(pc, et);
      lookup_pc = 32'h3000 + 32'(4 * $urandom_range(0, DEPTH - 1));
      #1;
      tests_run++;
      if (lookup_taken !== model_pred(lookup_pc)) begin
        tests_failed++; $display("FAIL compare_lookup pc=%h: got %b expected %b", lookup_pc, lookup_taken, model_pred(lookup_pc));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc_q[$];
    bit exp_t_q[$];
    bit exp_m_q[$];
    logic [31:0] epc;
    bit et, em;
    int n;
    n = 20;
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        tick();
        epc = exp_pc_q.pop_front(); et = exp_t_q.pop_front(); em = exp_m_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_taken !== et || out_mispredict !== em || out_pc !== epc) begin
          tests_failed++;
          $display("FAIL b2b beat %0d: got v=%b rdy=%b t=%b m=%b pc=%h expected v=1 rdy=1 t=%b m=%b pc=%h",
                   i, out_valid, in_ready, out_taken, out_mispredict, out_pc, et, em, epc);
        end
        model_update(epc, et);
      end
      if (i < n) begin
        in_pc = 32'h3000 + 32'(4 * $urandom_range(0, DEPTH - 1));
        b_ctrl = 3'($urandom_range(0, 7));
        rs_val = rand_operand();
        rt_val = ($urandom_range(0, 1) == 1) ? rs_val : rand_operand();
        pred_taken = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        et = ref_taken(b_ctrl, rs_val, rt_val);
        exp_pc_q.push_back(in_pc); exp_t_q.push_back(et); exp_m_q.push_back(et != pred_taken);
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
    for (int i = 0; i < DEPTH; i++) begin
      lookup_pc = 32'h3000 + 32'(4 * i);
      #1;
      tests_run++;
      if (lookup_taken !== model_pred(lookup_pc)) begin
        tests_failed++; $display("FAIL b2b_table pc=%h: got %b expected %b", lookup_pc, lookup_taken, model_pred(lookup_pc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic ov, ot, om;
    logic [31:0] opc;
    apply_reset();
    send(32'h3010, 3'b000, 32'd0, 32'd0, 1'b0, ov, ot, om, opc);
    model_update(32'h3010, 1'b0);
    in_pc = 32'h3010; b_ctrl = 3'b111; pred_taken = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_pc = 32'h3014; b_ctrl = 3'b111; pred_taken = 1'b1;
    lookup_pc = 32'h3010;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_taken !== 1'b1 || out_mispredict !== 1'b1 ||
          out_pc !== 32'h3010 || lookup_taken !== model_pred(32'h3010)) begin
        tests_failed++;
        $display("FAIL backpressure cycle %0d: got rdy=%b v=%b t=%b m=%b pc=%h lk=%b expected rdy=0 v=1 t=1 m=1 pc=3010 lk=%b",
                 k, in_ready, out_valid, out_taken, out_mispredict, out_pc, lookup_taken, model_pred(32'h3010));
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    model_update(32'h3010, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL backpressure_drain: got out_valid=%b expected 0", out_valid); end
    #1;
    tests_run++;
    if (lookup_taken !== model_pred(32'h3010)) begin
      tests_failed++; $display("FAIL backpressure_single_update: got %b expected %b", lookup_taken, model_pred(32'h3010));
    end
    lookup_pc = 32'h3014;
    #1;
    tests_run++;
    if (lookup_taken !== model_pred(32'h3014)) begin
      tests_failed++; $display("FAIL backpressure_blocked_req: got %b expected %b", lookup_taken, model_pred(32'h3014));
    end
  endtask

  task automatic test_saturation();
    logic ov, ot, om;
    logic [31:0] opc;
    bit et;
    logic [2:0] c;
    apply_reset();
    lookup_pc = 32'h3008;
    for (int k = 0; k < 7; k++) begin
      c = (k < 5) ? 3'b111 : 3'b000;
      send(32'h3008, c, 32'd0, 32'd0, 1'b1, ov, ot, om, opc);
      et = ref_taken(c, 32'd0, 32'd0);
      tests_run++;
      if (ot !== et || om !== (et != 1'b1)) begin
        tests_failed++; $display("FAIL saturation_out step %0d: got t=%b m=%b expected t=%b m=%b", k, ot, om, et, et != 1'b1);
      end
      model_update(32'h3008, et);
      #1;
      tests_run++;
      if (lookup_taken !== model_pred(32'h3008)) begin
        tests_failed++; $display("FAIL saturation_lookup step %0d: got %b expected %b", k, lookup_taken, model_pred(32'h3008));
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    in_pc = 32'h3020; b_ctrl = 3'b111; pred_taken = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_setup: got out_valid=%b expected 1", out_valid); end
    in_pc = 32'h3024; b_ctrl = 3'b111; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_clear: got out_valid=%b expected 0", out_valid); end
    lookup_pc = 32'h3020;
    #1;
    tests_run++;
    if (lookup_taken !== model_pred(32'h3020)) begin
      tests_failed++; $display("FAIL flush_no_update: got %b expected %b", lookup_taken, model_pred(32'h3020));
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_drop_new: got out_valid=%b expected 0", out_valid); end
    lookup_pc = 32'h3024;
    #1;
    tests_run++;
    if (lookup_taken !== model_pred(32'h3024)) begin
      tests_failed++; $display("FAIL flush_new_table: got %b expected %b", lookup_taken, model_pred(32'h3024));
    end
  endtask

  task automatic test_async_reset();
    logic ov, ot, om;
    logic [31:0] opc;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      send(32'h3030, 3'b111, 32'd0, 32'd0, 1'b1, ov, ot, om, opc);
      model_update(32'h3030, 1'b1);
    end
    lookup_pc = 32'h3030;
    #1;
    tests_run++;
    if (lookup_taken !== model_pred(32'h3030)) begin
      tests_failed++; $display("FAIL async_pretrain: got %b expected %b", lookup_taken, model_pred(32'h3030));
    end
    in_pc = 32'h3030; b_ctrl = 3'b111; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || lookup_taken !== model_pred(32'h3030)) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b pc=%h lk=%b expected v=0 pc=0 lk=%b", out_valid, out_pc, lookup_taken, model_pred(32'h3030));
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    lookup_pc = '0;
    idle_inputs();
    model_reset();
    test_reset();
    test_first_branch();
    test_compare_modes();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
